alu_arbiter: RTL and testbench

Shares one 16-bit two-input ALU (2-bit `sel` opcode, result plus carry flag `c`) between two requesters. Round-robin arbitration, a valid/ready request handshake and a held response handshake per requester. Operands are registered before the ALU, and the result is registered after it. Sits between the two datapath clients and the single ALU instance, and owns that instance.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_arbiter_alu.sv | 29 ++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, width and arbiter FSM state type
package alu_pkg;

   localparam int ALU_WIDTH = 16;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational two-input ALU with carry/borrow flag
module ALU
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] ALU_Result,
   output logic             c
);

   logic [WIDTH:0] ext;

   // Bit WIDTH is the carry on add and the borrow on subtract.
   always_comb begin
      ext = '0;
      case (sel)
         ALU_ADD: ext = {1'b0, a} + {1'b0, b};
         ALU_SUB: ext = {1'b0, a} - {1'b0, b};
         ALU_AND: ext = {1'b0, a & b};
         default: ext = {1'b0, a | b};
      endcase
      ALU_Result = ext[WIDTH-1:0];
      c          = ext[WIDTH];
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one registered ALU between two requesters
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_sel,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_c,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_c,
   output logic             busy
);

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [1:0]       op_sel_q, op_sel_d;
   logic             rsp0_valid_q, rsp0_valid_d;
   logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
   logic             rsp0_c_q, rsp0_c_d;
   logic             rsp1_valid_q, rsp1_valid_d;
   logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
   logic             rsp1_c_q, rsp1_c_d;

   logic             grant0, grant1;
   logic [WIDTH-1:0] alu_result;
   logic             alu_c;

   ALU #(.WIDTH(WIDTH)) u_alu (
      .a          (op_a_q),
      .b          (op_b_q),
      .sel        (op_sel_q),
      .ALU_Result (alu_result),
      .c          (alu_c)
   );

   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_q);
      grant1 = req1_valid & (~req0_valid | ~last_q);
      // Ready is masked during reset so no client believes a request was taken.
      req0_ready = ~rst & (state_q == IDLE) & grant0;
      req1_ready = ~rst & (state_q == IDLE) & grant1;

      state_d       = state_q;
      owner_d       = owner_q;
      last_d        = last_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      op_sel_d      = op_sel_q;
      rsp0_valid_d  = rsp0_valid_q;
      rsp0_result_d = rsp0_result_q;
      rsp0_c_d      = rsp0_c_q;
      rsp1_valid_d  = rsp1_valid_q;
      rsp1_result_d = rsp1_result_q;
      rsp1_c_d      = rsp1_c_q;

      case (state_q)
         IDLE: begin
            if (req0_ready || req1_ready) begin
               owner_d  = req1_ready;
               last_d   = req1_ready;
               op_a_d   = req1_ready ? req1_a   : req0_a;
               op_b_d   = req1_ready ? req1_b   : req0_b;
               op_sel_d = req1_ready ? req1_sel : req0_sel;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            if (owner_q) begin
               rsp1_valid_d  = 1'b1;
               rsp1_result_d = alu_result;
               rsp1_c_d      = alu_c;
            end else begin
               rsp0_valid_d  = 1'b1;
               rsp0_result_d = alu_result;
               rsp0_c_d      = alu_c;
            end
            state_d = RESP;
         end
         RESP: begin
            if (owner_q && rsp1_ready) begin
               rsp1_valid_d = 1'b0;
               state_d      = IDLE;
            end else if (!owner_q && rsp0_ready) begin
               rsp0_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         last_q        <= 1'b1;
         op_a_q        <= '0;
         op_b_q        <= '0;
         op_sel_q      <= '0;
         rsp0_valid_q  <= 1'b0;
         rsp0_result_q <= '0;
         rsp0_c_q      <= 1'b0;
         rsp1_valid_q  <= 1'b0;
         rsp1_result_q <= '0;
         rsp1_c_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_q        <= last_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         op_sel_q      <= op_sel_d;
         rsp0_valid_q  <= rsp0_valid_d;
         rsp0_result_q <= rsp0_result_d;
         rsp0_c_q      <= rsp0_c_d;
         rsp1_valid_q  <= rsp1_valid_d;
         rsp1_result_q <= rsp1_result_d;
         rsp1_c_q      <= rsp1_c_d;
      end
   end

   assign rsp0_valid  = rsp0_valid_q;
   assign rsp0_result = rsp0_result_q;
   assign rsp0_c      = rsp0_c_q;
   assign rsp1_valid  = rsp1_valid_q;
   assign rsp1_result = rsp1_result_q;
   assign rsp1_c      = rsp1_c_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with directed and random traffic
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int W = ALU_WIDTH;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0]   req0_sel, req1_sel;
   logic         rsp0_valid, rsp1_valid;
   logic         rsp0_ready, rsp1_ready;
   logic [W-1:0] rsp0_result, rsp1_result;
   logic         rsp0_c, rsp1_c;
   logic         busy;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_sel    (req0_sel),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_sel    (req1_sel),
      .rsp0_valid  (rsp0_valid),
      .rsp0_ready  (rsp0_ready),
      .rsp0_result (rsp0_result),
      .rsp0_c      (rsp0_c),
      .rsp1_valid  (rsp1_valid),
      .rsp1_ready  (rsp1_ready),
      .rsp1_result (rsp1_result),
      .rsp1_c      (rsp1_c),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      int           due;
   } exp_t;

   exp_t exp_q0[$];
   exp_t exp_q1[$];
   int   grant_id[$];
   int   grant_cyc[$];
   int   checks = 0;
   int   errors = 0;
   int   last_served = 1;
   bit   rand_rready = 1'b0;

   logic         pv[2];
   logic         pr[2];
   logic [W-1:0] pres[2];
   logic         pc[2];

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [1:0] sel, input int due);
      exp_t   e;
      longint la, lb, full;
      la = longint'(a);
      lb = longint'(b);
      e.due = due;
      e.c   = 1'b0;
      case (sel)
         ALU_ADD: begin
            full = la + lb;
            e.c  = (full >= (longint'(1) << W));
         end
         ALU_SUB: begin
            e.c  = (la < lb);
            full = la - lb + (e.c ? (longint'(1) << W) : 0);
         end
         ALU_AND: full = la & lb;
         default: full = la | lb;
      endcase
      e.res = full[W-1:0];
      return e;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] sel, input int maxwait, output int hs);
      hs = -1;
      if (id == 0) begin
         req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1;
      end
      for (int i = 0; i < maxwait; i++) begin
         @(negedge clk);
         if (!rst && (id == 0 ? req0_ready : req1_ready)) begin
            hs = cyc;
            if (id == 0) exp_q0.push_back(model(a, b, sel, cyc + 2));
            else         exp_q1.push_back(model(a, b, sel, cyc + 2));
            grant_id.push_back(id);
            grant_cyc.push_back(cyc);
            break;
         end
      end
      @(posedge clk);
      #1;
      if (id == 0) req0_valid = 1'b0;
      else         req1_valid = 1'b0;
   endtask

   task automatic wait_cycle(input int n);
      int guard = 0;
      while (cyc < n && guard < 1000) begin
         @(posedge clk);
         #1;
         guard++;
      end
   endtask

   task automatic wait_quiet();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (n < 200 && (busy || rsp0_valid || rsp1_valid || req0_valid || req1_valid ||
                             exp_q0.size() != 0 || exp_q1.size() != 0));
      check("quiet_timeout", n < 200, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic mon_rsp(input int id, input logic v, input logic rr,
                          input logic [W-1:0] r, input logic c);
      exp_t e;
      if (pv[id] && pr[id]) begin
         check(id == 0 ? "rsp0_drop" : "rsp1_drop", v, 0);
      end else if (pv[id]) begin
         check(id == 0 ? "rsp0_hold_valid" : "rsp1_hold_valid", v, 1);
         check(id == 0 ? "rsp0_hold_result" : "rsp1_hold_result", r, pres[id]);
         check(id == 0 ? "rsp0_hold_c" : "rsp1_hold_c", c, pc[id]);
      end else if (v) begin
         if ((id == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp%0d_unexpected: got valid=1 required no response (cycle %0d)", id, cyc);
         end else begin
            if (id == 0) e = exp_q0.pop_front();
            else         e = exp_q1.pop_front();
            check(id == 0 ? "rsp0_result" : "rsp1_result", r, e.res);
            check(id == 0 ? "rsp0_c" : "rsp1_c", c, e.c);
            check(id == 0 ? "rsp0_latency" : "rsp1_latency", cyc, e.due);
         end
      end
      pv[id]   = v;
      pr[id]   = rr;
      pres[id] = r;
      pc[id]   = c;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         pv[0] = 1'b0;
         pv[1] = 1'b0;
      end else begin
         check("ready_onehot", req0_ready & req1_ready, 0);
         if (busy) begin
            check("ready0_busy", req0_ready, 0);
            check("ready1_busy", req1_ready, 0);
         end else begin
            check("grant0", req0_ready, req0_valid & (~req1_valid | (last_served == 1)));
            check("grant1", req1_ready, req1_valid & (~req0_valid | (last_served == 0)));
         end
         check("rsp_without_busy", (rsp0_valid | rsp1_valid) & ~busy, 0);
         mon_rsp(0, rsp0_valid, rsp0_ready, rsp0_result, rsp0_c);
         mon_rsp(1, rsp1_valid, rsp1_ready, rsp1_result, rsp1_c);
         if (req0_valid && req0_ready) last_served = 0;
         if (req1_valid && req1_ready) last_served = 1;
      end
   end

   always @(posedge clk) begin
      if (rand_rready) begin
         #1;
         rsp0_ready = ($urandom_range(0, 3) != 0);
         rsp1_ready = ($urandom_range(0, 3) != 0);
      end
   end

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 3))
         0:       return '1;
         1:       return '0;
         default: return W'($urandom);
      endcase
   endfunction

   task automatic rand_client(input int id);
      int           h;
      logic [W-1:0] a, b;
      logic [1:0]   s;
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         a = pick();
         b = pick();
         s = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) begin
            issue(id, a, b, s, 1, h);
         end else begin
            issue(id, a, b, s, 300, h);
            check("accept_timeout", h >= 0, 1);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   initial begin
      int   h, h0, h1, ha, hb, hc, hd;
      exp_t e;
      int   exp_ids[4];
      exp_ids = '{0, 1, 0, 1};

      rst = 1'b1;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0F0F; req0_sel = ALU_ADD;
      req1_valid = 1'b1; req1_a = 16'h4321; req1_b = 16'h00FF; req1_sel = ALU_OR;
      repeat (2) begin
         @(negedge clk);
         check("rst_ready0", req0_ready, 0);
         check("rst_ready1", req1_ready, 0);
         check("rst_rsp0_valid", rsp0_valid, 0);
         check("rst_rsp1_valid", rsp1_valid, 0);
         check("rst_rsp0_result", rsp0_result, 0);
         check("rst_rsp1_result", rsp1_result, 0);
         check("rst_busy", busy, 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      grant_id.delete(); grant_cyc.delete();
      fork
         issue(0, 16'h0007, 16'h0009, ALU_ADD, 50, h0);
         issue(1, 16'h0004, 16'h0001, ALU_SUB, 50, h1);
      join
      check("first_grant_req0", grant_id[0], 0);
      check("first_tie_interval", h1 - h0, 3);
      wait_quiet();

      issue(0, 16'd3, 16'd2, ALU_ADD, 50, h);
      @(negedge clk);
      check("add_busy_t1", busy, 1);
      check("add_valid_t1", rsp0_valid, 0);
      @(negedge clk);
      check("add_busy_t2", busy, 1);
      check("add_valid_t2", rsp0_valid, 1);
      check("add_result", rsp0_result, 5);
      check("add_c", rsp0_c, 0);
      check("add_rsp1_idle", rsp1_valid, 0);
      @(negedge clk);
      check("add_busy_t3", busy, 0);
      wait_quiet();

      issue(1, 16'hFFFF, 16'h0001, ALU_ADD, 50, h);
      wait_quiet();
      check("carry_result_kept", rsp1_result, 0);
      check("carry_c_kept", rsp1_c, 1);

      for (int s = 0; s < 4; s++) begin
         issue(0, 16'd3, 16'd2, 2'(s), 50, h);
         wait_quiet();
         e = model(16'd3, 16'd2, 2'(s), 0);
         check("sweep_result", rsp0_result, e.res);
      end

      rsp0_ready = 1'b0;
      issue(0, 16'd10, 16'd20, ALU_SUB, 50, h0);
      fork
         issue(1, 16'h00F5, 16'h0036, ALU_AND, 100, h1);
         begin
            wait_cycle(h0 + 6);
            rsp0_ready = 1'b1;
         end
      join
      check("backpressure_accept_cycle", h1, h0 + 7);
      wait_quiet();

      grant_id.delete(); grant_cyc.delete();
      fork
         begin
            issue(0, 16'd3, 16'd2, ALU_ADD, 50, ha);
            issue(0, 16'd3, 16'd2, ALU_ADD, 50, hb);
         end
         begin
            issue(1, 16'd3, 16'd2, ALU_OR, 50, hc);
            issue(1, 16'd3, 16'd2, ALU_OR, 50, hd);
         end
      join
      check("tie_grant_count", grant_id.size(), 4);
      for (int i = 0; i < 4 && i < grant_id.size(); i++) begin
         check("tie_grant_order", grant_id[i], exp_ids[i]);
         if (i > 0) check("tie_interval", grant_cyc[i] - grant_cyc[i-1], 3);
      end
      wait_quiet();

      issue(0, 16'd100, 16'd200, ALU_ADD, 50, h);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q0.delete(); exp_q1.delete();
      last_served = 1;
      grant_id.delete(); grant_cyc.delete();
      fork
         issue(0, 16'd1, 16'd1, ALU_ADD, 50, ha);
         issue(1, 16'd2, 16'd2, ALU_ADD, 50, hb);
         begin
            @(negedge clk);
            check("midrst_busy", busy, 0);
            check("midrst_rsp0_valid", rsp0_valid, 0);
            check("midrst_rsp1_valid", rsp1_valid, 0);
            check("midrst_rsp0_result", rsp0_result, 0);
            check("midrst_rsp1_result", rsp1_result, 0);
            check("midrst_ready0", req0_ready, 1);
            check("midrst_ready1", req1_ready, 0);
         end
      join
      check("midrst_first_grant", grant_id[0], 0);
      check("midrst_second_grant", hb - ha, 3);
      wait_quiet();

      rand_rready = 1'b1;
      fork
         rand_client(0);
         rand_client(1);
      join
      rand_rready = 1'b0;
      @(posedge clk);
      #2;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      wait_quiet();

      check("final_q0_empty", exp_q0.size(), 0);
      check("final_q1_empty", exp_q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
